// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state type and default width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier datapath: one partial-product step per enabled cycle.
// product_o is the accumulator value after the step currently in progress,
// so the controller can capture the finished product on the final step edge.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             last_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_sum;

    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = acc_sum;
    assign last_o    = (cnt_q == LAST_CNT);

    // Next-state: load fresh operands, or advance one shift-add step.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_sum;
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; reset clears any multiply in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle add/sub/slt, multi-cycle shift-add multiply.
// Results, the Zero flag and the done pulse are all registered.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic             mul_load, mul_step, mul_last;
    logic [WIDTH-1:0] mul_product;

    logic signed [WIDTH-1:0] src_a_s, src_b_s;

    assign src_a_s = SrcA;
    assign src_b_s = SrcB;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .mcand_i   (SrcA),
        .mplier_i  (SrcB),
        .last_o    (mul_last),
        .product_o (mul_product)
    );

    // Next-state and result selection; start is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUControl == ALU_MUL) begin
                        mul_load = 1'b1;
                        state_d  = MUL;
                    end else begin
                        case (ALUControl)
                            ALU_ADD: res_d = SrcA + SrcB;
                            ALU_SUB: res_d = SrcA - SrcB;
                            ALU_SLT: res_d = {{(WIDTH-1){1'b0}}, (src_a_s < src_b_s)};
                            default: res_d = '0;
                        endcase
                        zero_d = (res_d == '0);
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    res_d   = mul_product;
                    zero_d  = (mul_product == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == MUL);
    assign done      = done_q;
    assign ALUResult = res_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA, SrcB;
    logic         busy, done, Zero;
    logic [W-1:0] ALUResult;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] last_res;

    alu_exec_unit #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .done       (done),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what the operation means arithmetically.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            3'b010:  return a + b;
            3'b100:  return a - b;
            3'b110:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'b101: begin
                p = 64'(a) * 64'(b);
                return p[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Issue one operation at a negedge and check its completion; leaves the
    // bench at the negedge where done is visible.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] exp;
        int busy_cyc;
        int early_done;
        exp = ref_alu(op, a, b);
        ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom);
        if (op == ALU_MUL) begin
            busy_cyc = 0; early_done = 0;
            while (busy && busy_cyc < 40) begin
                if (done) early_done++;
                @(negedge CLK);
                SrcA = $urandom; SrcB = $urandom;
                busy_cyc++;
            end
            check_val({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(W));
            check_val({tag, "_early_done"}, 64'(early_done), 64'd0);
        end
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_result"}, 64'(ALUResult), 64'(exp));
        check_val({tag, "_zero"}, 64'(Zero), 64'(exp == '0));
        last_res = exp;
    endtask

    initial begin
        int dones;
        logic [2:0] op;
        logic [W-1:0] a, b;
        logic [2:0] other_codes [4];
        logic [W-1:0] special [4];
        other_codes = '{3'b000, 3'b001, 3'b011, 3'b111};
        special     = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        RST = 1'b0; start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
        #3;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_result", 64'(ALUResult), 64'd0);
        check_val("rst_zero", 64'(Zero), 64'd0);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // add, then done must fall with no new request
        run_op("add", ALU_ADD, 32'd5, 32'd7);
        @(negedge CLK);
        check_val("add_done_once", 64'(done), 64'd0);
        check_val("add_hold", 64'(ALUResult), 64'd12);

        // sub then slt on consecutive edges
        ALUControl = ALU_SUB; SrcA = 32'd7; SrcB = 32'd7; start = 1'b1;
        @(negedge CLK);
        check_val("sub_done", 64'(done), 64'd1);
        check_val("sub_result", 64'(ALUResult), 64'd0);
        check_val("sub_zero", 64'(Zero), 64'd1);
        ALUControl = ALU_SLT; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
        @(negedge CLK);
        start = 1'b0;
        check_val("slt_done", 64'(done), 64'd1);
        check_val("slt_result", 64'(ALUResult), 64'd1);
        check_val("slt_zero", 64'(Zero), 64'd0);
        @(negedge CLK);
        check_val("slt_done_fall", 64'(done), 64'd0);

        // mul with wrap-around
        run_op("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd3);
        @(negedge CLK);
        check_val("mul_done_fall", 64'(done), 64'd0);

        // start during busy is ignored
        ALUControl = ALU_MUL; SrcA = 32'd6; SrcB = 32'd7; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) dones++;
            if (c == 5) begin
                ALUControl = ALU_ADD; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
        end
        check_val("ignore_result", 64'(ALUResult), 64'd42);
        check_val("ignore_done_count", 64'(dones), 64'd1);
        check_val("ignore_busy", 64'(busy), 64'd0);

        // start held through the completion edge is not taken
        ALUControl = ALU_MUL; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1;
        @(negedge CLK);
        ALUControl = ALU_ADD; SrcA = 32'd100; SrcB = 32'd100;
        for (int c = 0; c < 40 && busy; c++) @(negedge CLK);
        start = 1'b0;
        check_val("hold_start_done", 64'(done), 64'd1);
        check_val("hold_start_result", 64'(ALUResult), 64'd9);
        @(negedge CLK);
        check_val("hold_start_no_extra", 64'(done), 64'd0);
        check_val("hold_start_keep", 64'(ALUResult), 64'd9);

        // reset in the middle of a multiply
        ALUControl = ALU_MUL; SrcA = 32'd123; SrcB = 32'd456; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_val("mrst_busy", 64'(busy), 64'd0);
        check_val("mrst_done", 64'(done), 64'd0);
        check_val("mrst_result", 64'(ALUResult), 64'd0);
        check_val("mrst_zero", 64'(Zero), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        run_op("post_rst_add", ALU_ADD, 32'd2, 32'd2);
        @(negedge CLK);
        check_val("post_rst_no_late_done", 64'(done), 64'd0);

        // illegal opcode
        run_op("illegal", 3'b111, 32'd9, 32'd9);
        @(negedge CLK);

        // idle with no request: nothing but done may change
        SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234; ALUControl = ALU_ADD;
        @(negedge CLK);
        check_val("idle_hold_result", 64'(ALUResult), 64'd0);
        check_val("idle_hold_zero", 64'(Zero), 64'd1);

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = ALU_ADD;
                1: op = ALU_SUB;
                2: op = ALU_SLT;
                3: op = ALU_MUL;
                default: op = other_codes[$urandom_range(0, 3)];
            endcase
            a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : W'($urandom);
            run_op($sformatf("rnd%0d", n), op, a, b);
            repeat ($urandom_range(1, 2)) begin
                SrcA = $urandom; SrcB = $urandom;
                @(negedge CLK);
                check_val($sformatf("rnd%0d_gap_done", n), 64'(done), 64'd0);
                check_val($sformatf("rnd%0d_gap_hold", n), 64'(ALUResult), 64'(last_res));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to execute; sampled only while busy=0.
REQ-005 The block SHALL have port ALUControl, input, 3, the operation code: 010 add, 100 sub, 110 slt, 101 mul.
REQ-006 The block SHALL have ports SrcA and SrcB, input, WIDTH each, the operands, sampled on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, asserted while a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking a new valid ALUResult.
REQ-009 The block SHALL have port ALUResult, output, WIDTH, the registered result of the last completed operation.
REQ-010 The block SHALL have port Zero, output, 1, a registered flag set when the completed ALUResult equals 0.

Function
REQ-011 The FSM SHALL have two states, IDLE and MUL; busy=1 exactly when the state is MUL.
REQ-012 In IDLE, a rising edge with start=1 SHALL accept the request; with start=0, no outputs other than done SHALL change.
REQ-013 Add, sub and slt SHALL complete on the accepting edge, with latency 1: ALUResult, Zero and done=1 are visible in the following cycle, and the state stays IDLE.
REQ-014 Add and sub SHALL be modulo 2^WIDTH; carry and overflow SHALL be discarded.
REQ-015 slt SHALL compare signed two's complement operands and return 1 if SrcA<SrcB, else 0, zero-extended.
REQ-016 Any other ALUControl code SHALL complete like a 1-cycle op, with ALUResult=0, Zero=1 and done=1.
REQ-017 Mul SHALL, on the accepting edge, load the multiplicand (SrcA), the multiplier (SrcB), the accumulator (0) and the iteration count (0), and enter MUL.
REQ-018 On each MUL edge the block SHALL do one shift-add step: if the multiplier LSB=1, add the multiplicand to the accumulator; shift the multiplicand left by 1; shift the multiplier right by 1; increment the count.
REQ-019 On the WIDTH-th MUL edge, the block SHALL write the accumulator into ALUResult (low WIDTH bits of the unsigned product), update Zero, pulse done and return to IDLE.
REQ-020 The total mul latency SHALL be WIDTH+1 edges from acceptance, with busy high for exactly WIDTH cycles.
REQ-021 start during MUL SHALL be ignored and not queued, and the in-flight operands SHALL be unaffected by changes on SrcA, SrcB or ALUControl.
REQ-022 Back-to-back 1-cycle ops SHALL be accepted on consecutive edges, with done held high on consecutive cycles.
REQ-023 A start present on the same edge as the mul-completion edge SHALL be ignored, because busy=1 on that edge.
REQ-024 ALUResult and Zero SHALL hold their values between completions.
REQ-025 done SHALL never be high for more than one cycle per accepted request.

Reset
REQ-026 RST=0 SHALL force, asynchronously, state IDLE, busy=0, done=0, ALUResult=0, Zero=0, and clear the accumulator, count and operand registers.
REQ-027 Reset during MUL SHALL abort the multiply with no done pulse; the first edge after RST returns high SHALL accept a new start.

Structure
REQ-028 A shared package alu_pkg SHALL hold the ALUControl code constants (ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL), the FSM state typedef and the default WIDTH; the existing decoder SHALL use the same constants.
REQ-029 The shift-add datapath (accumulator, shifting operands, counter) SHALL be a single sub-module, seq_multiplier, controlled by alu_exec_unit through load, step and last signals.

Verification
REQ-030 The bench SHALL check add: start with 010, SrcA=5, SrcB=7 -> next cycle ALUResult=12, Zero=0, done=1 for one cycle, busy=0.
REQ-031 The bench SHALL check sub and slt: 100 with 7,7 -> ALUResult=0, Zero=1; then 110 with 0xFFFFFFFF,1 on the next edge -> ALUResult=1, with done high in two consecutive cycles.
REQ-032 The bench SHALL check mul: 101 with 0xFFFFFFFF,3 -> busy high for 32 cycles, then ALUResult=0xFFFFFFFD, Zero=0, done pulsed at edge 33.
REQ-033 The bench SHALL check start during busy: add 1,1 issued at MUL cycle 5 of 6*7 -> ignored; final ALUResult=42 with exactly one done pulse.
REQ-034 The bench SHALL check reset mid-mul: RST low at MUL cycle 10 -> all outputs 0 immediately, no done; after release, add 2,2 -> ALUResult=4 one cycle later.
REQ-035 The bench SHALL check an illegal code: 111 with 9,9 -> ALUResult=0, Zero=1, done=1 after 1 cycle.
